// File: rtl/acc_result_wbuf.sv
// Output stage after pipeline_acc: bias, optional ReLU, rounding shift and saturation,
// then packs C_PACK elements per word into the output buffer under start/busy/done control.
module acc_result_wbuf #(
  parameter int C_IN      = 13,
  parameter int C_OB      = 8,
  parameter int C_SHIFT_W = 4,
  parameter int C_PACK    = 4,
  parameter int C_AW      = 10,
  parameter int C_PRE     = 4
) (
  input  logic                   I_clk,
  input  logic                   I_rst,
  input  logic                   I_start,
  input  logic [C_AW-1:0]        I_total,
  input  logic [C_SHIFT_W-1:0]   I_shift,
  input  logic [C_IN-1:0]        I_bias,
  input  logic                   I_relu_en,
  input  logic                   I_result_rdy_pre4,
  input  logic [C_IN-1:0]        I_result,
  output logic                   O_wr_en,
  output logic [C_AW-1:0]        O_wr_addr,
  output logic [C_OB*C_PACK-1:0] O_wr_data,
  output logic                   O_busy,
  output logic                   O_done,
  output logic                   O_ovf
);

  localparam int C_SW = C_IN + 1;
  // Wide enough for the biased sum plus the largest rounding term without wrapping.
  localparam int RW = (C_IN + 2 > (1 << C_SHIFT_W) + 1) ? C_IN + 2 : (1 << C_SHIFT_W) + 1;
  localparam int LW = $clog2(C_PACK);
  localparam logic [LW-1:0] LANE_LAST = LW'(C_PACK - 1);
  localparam logic signed [RW-1:0] SAT_HI = RW'((1 << (C_OB - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_LO = -RW'(1 << (C_OB - 1));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                         state;
  logic [C_AW-1:0]                total_q;
  logic [C_SHIFT_W-1:0]           shift_q;
  logic signed [C_IN-1:0]         bias_q;
  logic                           relu_q;
  logic [C_PRE-1:0]               pre_sr;
  logic                           v1, v2, v3;
  logic signed [C_SW-1:0]         sum1;
  logic signed [RW-1:0]           r2;
  logic [C_OB-1:0]                e3;
  logic [C_PACK-1:0][C_OB-1:0]    lanes;
  logic [LW-1:0]                  lane_cnt;
  logic [C_AW-1:0]                word_cnt;
  logic                           fin;

  logic                           run;
  logic signed [C_SW-1:0]         sum_next;
  logic signed [C_SW-1:0]         relu_sum;
  logic signed [RW-1:0]           ext, rnd, r_next;
  logic [C_OB-1:0]                elem_next;
  logic                           sat_hit;
  logic [C_PACK-1:0][C_OB-1:0]    word_next;

  assign run    = (state == S_RUN);
  assign O_busy = run;
  assign O_done = (state == S_DONE);

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    sum_next  = C_SW'($signed(I_result)) + C_SW'(bias_q);
    relu_sum  = (relu_q && sum1[C_SW-1]) ? '0 : sum1;
    ext       = RW'(relu_sum);
    rnd       = (shift_q == '0) ? '0 : (RW'(1) << (shift_q - 1'b1));
    r_next    = (ext + rnd) >>> shift_q;
    sat_hit   = 1'b0;
    elem_next = r2[C_OB-1:0];
    if (r2 > SAT_HI) begin
      sat_hit   = 1'b1;
      elem_next = SAT_HI[C_OB-1:0];
    end else if (relu_q && r2 < 0) begin
      sat_hit   = 1'b1;
      elem_next = '0;
    end else if (r2 < SAT_LO) begin
      sat_hit   = 1'b1;
      elem_next = SAT_LO[C_OB-1:0];
    end
    word_next           = lanes;
    word_next[lane_cnt] = e3;
  end

  // NOTE: sequential state uses non-blocking assignments only, so stage order cannot race.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state     <= S_IDLE;
      total_q   <= '0;
      shift_q   <= '0;
      bias_q    <= '0;
      relu_q    <= 1'b0;
      pre_sr    <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      sum1      <= '0;
      r2        <= '0;
      e3        <= '0;
      lanes     <= '0;
      lane_cnt  <= '0;
      word_cnt  <= '0;
      fin       <= 1'b0;
      O_wr_en   <= 1'b0;
      O_wr_addr <= '0;
      O_wr_data <= '0;
      O_ovf     <= 1'b0;
    end else begin
      O_wr_en <= 1'b0;
      if (I_start) begin
        state    <= S_RUN;
        total_q  <= I_total;
        shift_q  <= I_shift;
        bias_q   <= I_bias;
        relu_q   <= I_relu_en;
        pre_sr   <= '0;
        v1       <= 1'b0;
        v2       <= 1'b0;
        v3       <= 1'b0;
        lanes    <= '0;
        lane_cnt <= '0;
        word_cnt <= '0;
        fin      <= 1'b0;
        O_ovf    <= 1'b0;
      end else begin
        pre_sr <= {pre_sr[C_PRE-2:0], I_result_rdy_pre4 & run};
        v1     <= pre_sr[C_PRE-1] & run;
        sum1   <= sum_next;
        v2     <= v1;
        r2     <= r_next;
        v3     <= v2;
        e3     <= elem_next;
        if (v2 && sat_hit) O_ovf <= 1'b1;

        // Once the last word is out, anything still in the pipe is dropped.
        if (v3 && run && !fin) begin
          lanes <= word_next;
          if (lane_cnt == LANE_LAST) begin
            O_wr_en   <= 1'b1;
            O_wr_addr <= word_cnt;
            O_wr_data <= word_next;
            lane_cnt  <= '0;
            word_cnt  <= word_cnt + C_AW'(1);
            if (word_cnt == total_q - C_AW'(1)) fin <= 1'b1;
          end else begin
            lane_cnt <= lane_cnt + LW'(1);
          end
        end

        case (state)
          S_RUN:   if (fin) state <= S_DONE;
          S_DONE: begin
            state <= S_IDLE;
            fin   <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acc_result_wbuf.sv
// Scoreboard bench for acc_result_wbuf: an arithmetic reference model predicts every packed
// write; a monitor compares writes, done/busy timing and data hold against those predictions.
module tb_acc_result_wbuf;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_start = 1'b0;
  logic [9:0]  I_total = '0;
  logic [3:0]  I_shift = '0;
  logic [12:0] I_bias = '0;
  logic        I_relu_en = 1'b0;
  logic        I_result_rdy_pre4 = 1'b0;
  logic [12:0] I_result = '0;
  logic        O_wr_en;
  logic [9:0]  O_wr_addr;
  logic [31:0] O_wr_data;
  logic        O_busy, O_done, O_ovf;

  acc_result_wbuf dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_start(I_start), .I_total(I_total),
    .I_shift(I_shift), .I_bias(I_bias), .I_relu_en(I_relu_en),
    .I_result_rdy_pre4(I_result_rdy_pre4), .I_result(I_result),
    .O_wr_en(O_wr_en), .O_wr_addr(O_wr_addr), .O_wr_data(O_wr_data),
    .O_busy(O_busy), .O_done(O_done), .O_ovf(O_ovf)
  );

  always #5 I_clk = ~I_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: layer config plus running element count and word under construction.
  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    bit          last;
  } wr_t;

  wr_t         exp_q[$];
  int          m_total, m_shift, m_bias, m_cnt;
  bit          m_relu, m_ovf, m_active;
  logic [31:0] m_word;

  function automatic int floor_div(input int x, input int d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic int quant(input int res, output bit sat);
    int s, q, lo;
    s = res + m_bias;
    if (m_relu && s < 0) s = 0;
    q = (m_shift > 0) ? floor_div(s + (1 << (m_shift - 1)), 1 << m_shift) : s;
    lo  = m_relu ? 0 : -128;
    sat = 1'b0;
    if (q > 127) begin q = 127; sat = 1'b1; end
    else if (q < lo) begin q = lo; sat = 1'b1; end
    return q;
  endfunction

  task automatic model_accept(input int res);
    int  e;
    bit  sat;
    wr_t it;
    if (!m_active || m_cnt >= m_total * 4) return;
    e = quant(res, sat);
    if (sat) m_ovf = 1'b1;
    m_word[(m_cnt % 4) * 8 +: 8] = e[7:0];
    m_cnt++;
    if (m_cnt % 4 == 0) begin
      it.addr = 10'(m_cnt / 4 - 1);
      it.data = m_word;
      it.last = (m_cnt == m_total * 4);
      exp_q.push_back(it);
    end
  endtask

  // Data follows its ready flag by four cycles; a schedule keyed by cycle drives it.
  int cyc = 0;
  int sched[int];
  always @(posedge I_clk) cyc++;
  always @(negedge I_clk) begin
    if (sched.exists(cyc)) begin
      I_result = 13'(sched[cyc]);
      sched.delete(cyc);
    end else begin
      I_result = 13'($urandom);
    end
  end

  // Monitor: compares each write against the scoreboard and checks done/busy/hold timing.
  bit          done_pend = 1'b0;
  logic [31:0] last_data = '0;
  wr_t         mon_it;
  always @(negedge I_clk) begin
    if (I_rst) begin
      done_pend = 1'b0;
      last_data = '0;
    end else begin
      check("done_pulse", O_done, done_pend);
      if (O_done) check("busy_low_at_done", O_busy, 0);
      done_pend = 1'b0;
      if (O_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", O_wr_en, 0);
        end else begin
          mon_it = exp_q.pop_front();
          check("wr_addr", O_wr_addr, mon_it.addr);
          check("wr_data", O_wr_data, mon_it.data);
          if (mon_it.last) check("busy_at_last_write", O_busy, 1);
          done_pend = mon_it.last;
        end
        last_data = O_wr_data;
      end else begin
        check("wr_data_hold", O_wr_data, last_data);
      end
    end
  end

  task automatic start_layer(input int total, input int shift, input int bias, input bit relu);
    @(negedge I_clk);
    I_start   = 1'b1;
    I_total   = 10'(total);
    I_shift   = 4'(shift);
    I_bias    = 13'(bias);
    I_relu_en = relu;
    m_total = total; m_shift = shift; m_bias = bias; m_relu = relu;
    m_cnt = 0; m_ovf = 1'b0; m_active = 1'b1; m_word = '0;
    @(negedge I_clk);
    I_start = 1'b0;
    check("busy_after_start", O_busy, 1);
    check("ovf_after_start", O_ovf, 0);
  endtask

  task automatic push(input int vals[$], input int max_gap);
    foreach (vals[i]) begin
      @(negedge I_clk);
      I_result_rdy_pre4 = 1'b1;
      sched[cyc + 4] = vals[i];
      model_accept(vals[i]);
      repeat ($urandom_range(0, max_gap)) begin
        @(negedge I_clk);
        I_result_rdy_pre4 = 1'b0;
      end
    end
    @(negedge I_clk);
    I_result_rdy_pre4 = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge I_clk);
      n++;
    end while (!O_done && n < 300);
    check({name, "_done_seen"}, O_done, 1);
    check({name, "_ovf"}, O_ovf, m_ovf);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  int v[$];

  initial begin
    repeat (2) @(negedge I_clk);
    check("rst_wr_en", O_wr_en, 0);
    check("rst_busy", O_busy, 0);
    check("rst_done", O_done, 0);
    check("rst_ovf", O_ovf, 0);
    check("rst_wr_data", O_wr_data, 0);
    I_rst = 1'b0;

    // Straight packing, no transform.
    start_layer(1, 0, 0, 0);
    v = '{1, 2, 3, 4};
    push(v, 0);
    wait_done("t1");
    repeat (4) @(negedge I_clk);

    // Rounding on both signs.
    start_layer(1, 2, -3, 0);
    v = '{13, -7, 0, 5};
    push(v, 1);
    wait_done("t2");

    // ReLU clamp and saturation, then negative saturation without ReLU.
    start_layer(1, 0, 0, 1);
    v = '{-100, 300, 127, 50};
    push(v, 0);
    wait_done("t3a");
    start_layer(1, 0, 0, 0);
    v = '{-300, 0, 0, 0};
    push(v, 0);
    wait_done("t3b");

    // Three words back-to-back with one surplus result.
    start_layer(3, 0, 0, 0);
    v.delete();
    for (int i = 0; i < 13; i++) v.push_back(i * 9 - 50);
    push(v, 0);
    wait_done("t4");
    repeat (12) @(negedge I_clk);
    check("t4_busy_idle", O_busy, 0);

    // Restart mid-layer: partial word dropped, ovf and addresses restart.
    start_layer(2, 0, 0, 0);
    v = '{500, 1, 2, 3, 4, 5};
    push(v, 0);
    repeat (15) @(negedge I_clk);
    check("t5_ovf_before_restart", O_ovf, 1);
    start_layer(1, 1, 7, 0);
    v = '{20, -20, 33, -33};
    push(v, 0);
    wait_done("t5");

    // Asynchronous reset with data in flight.
    start_layer(2, 0, 0, 0);
    v = '{9, 8, 7, 6, 5, 4};
    push(v, 0);
    #2 I_rst = 1'b1;
    #1;
    check("t6_rst_wr_en", O_wr_en, 0);
    check("t6_rst_busy", O_busy, 0);
    check("t6_rst_done", O_done, 0);
    check("t6_rst_ovf", O_ovf, 0);
    check("t6_rst_addr", O_wr_addr, 0);
    check("t6_rst_data", O_wr_data, 0);
    exp_q.delete();
    m_active = 1'b0;
    @(negedge I_clk);
    @(negedge I_clk);
    I_rst = 1'b0;
    v = '{1, 2, 3, 4};
    push(v, 0);
    repeat (20) @(negedge I_clk);
    check("t6_idle_after_rst", O_busy, 0);

    // Randomized layers.
    for (int l = 0; l < 6; l++) begin
      start_layer($urandom_range(1, 4), $urandom_range(0, 15),
                  int'($urandom_range(0, 8191)) - 4096, 1'($urandom_range(0, 1)));
      v.delete();
      for (int i = 0; i < m_total * 4; i++) v.push_back(int'($urandom_range(0, 8191)) - 4096);
      push(v, 2);
      wait_done($sformatf("rnd%0d", l));
      repeat (6) @(negedge I_clk);
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
